// File: rtl/mc_front_end.sv
// Multi-channel stream input front end.
// Drains NCH FSL slave channels into the datapath in round-robin bursts of
// 1<<sizeburst words, moving `size` words per channel per run, and pulses
// `done` once every channel has delivered its full count.
module mc_front_end #(
    parameter int NCH       = 4,
    parameter int SIZECOUNT = 12,
    parameter int SIZEBURST = 4,
    localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 start,
    input  logic [SIZECOUNT-1:0] size,
    input  logic [SIZEBURST-1:0] sizeburst,
    input  logic [NCH-1:0]       FSL_S_EXISTS,
    input  logic [NCH-1:0]       rd_FSMctrl,
    input  logic [NCH-1:0]       OUT_rdy,
    output logic [NCH-1:0]       FSL_S_READ,
    output logic [NCH-1:0]       IN_send,
    output logic [SIZECOUNT:0]   IN_count,
    output logic [CH_W-1:0]      ch_sel,
    output logic                 busy,
    output logic                 done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] ARB  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]           state;
    logic [SIZECOUNT-1:0] size_l;
    logic [SIZEBURST-1:0] sb_l;
    logic [SIZECOUNT-1:0] wcnt [NCH];
    logic [SIZECOUNT-1:0] bcnt;

    logic                 word_xfer;
    logic                 burst_end;
    logic                 all_done;
    logic [CH_W-1:0]      next_ch;
    logic [CH_W-1:0]      cand;
    logic                 found;
    logic [NCH-1:0]       sel_onehot;

    // Burst length follows the latched sizeburst; SIZECOUNT+1 bits keep the largest burst representable.
    assign IN_count = (SIZECOUNT+1)'(1) << sb_l;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    assign sel_onehot = NCH'(1) << ch_sel;

    // Word handshake, burst termination, run completion and next-channel search.
    always_comb begin
        word_xfer = 1'b0;
        burst_end = 1'b0;
        all_done  = 1'b1;
        next_ch   = ch_sel;
        cand      = '0;
        found     = 1'b0;

        // Reset and clear block the strobes of the cycle they are asserted in.
        if (state == XFER && rst && !clear) begin
            word_xfer = FSL_S_EXISTS[ch_sel] && OUT_rdy[ch_sel];
        end

        burst_end = (({1'b0, bcnt} + (SIZECOUNT+1)'(1)) == IN_count) ||
                    ((wcnt[ch_sel] + SIZECOUNT'(1)) == size_l);

        // Completion looks at the counts as they will be after the current word.
        for (int i = 0; i < NCH; i++) begin
            if (CH_W'(i) == ch_sel) begin
                if ((wcnt[i] + SIZECOUNT'(1)) != size_l) all_done = 1'b0;
            end else if (wcnt[i] != size_l) begin
                all_done = 1'b0;
            end
        end

        // Search upward from the current channel with wrap, skipping finished channels.
        for (int k = 1; k <= NCH; k++) begin
            cand = CH_W'((int'(ch_sel) + k) % NCH);
            if (!found && (wcnt[cand] != size_l)) begin
                next_ch = cand;
                found   = 1'b1;
            end
        end
    end

    // Read strobe merges the FSM handshake with the external control read.
    always_comb begin
        IN_send    = {NCH{word_xfer}} & sel_onehot;
        FSL_S_READ = IN_send | rd_FSMctrl;
    end

    // Run length is data: latched on an accepted start, no reset needed.
    always_ff @(posedge clk) begin
        if (rst && !clear && state == IDLE && start) begin
            size_l <= size;
        end
    end

    // Control FSM with per-channel word counters and the shared burst counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            ch_sel <= '0;
            bcnt   <= '0;
            sb_l   <= '0;
            for (int i = 0; i < NCH; i++) wcnt[i] <= '0;
        end else if (clear) begin
            state  <= IDLE;
            ch_sel <= '0;
            bcnt   <= '0;
            for (int i = 0; i < NCH; i++) wcnt[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sb_l   <= sizeburst;
                        ch_sel <= '0;
                        bcnt   <= '0;
                        for (int i = 0; i < NCH; i++) wcnt[i] <= '0;
                        state  <= (size == '0) ? DONE : XFER;
                    end
                end
                XFER: begin
                    if (word_xfer) begin
                        wcnt[ch_sel] <= wcnt[ch_sel] + SIZECOUNT'(1);
                        bcnt         <= bcnt + SIZECOUNT'(1);
                        if (burst_end) begin
                            state <= all_done ? DONE : ARB;
                        end
                    end
                end
                ARB: begin
                    bcnt   <= '0;
                    ch_sel <= next_ch;
                    state  <= XFER;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_front_end.sv
// Scoreboard bench for mc_front_end: expected channel order is queued when a
// run is launched and compared against the sends observed from the DUT.
module tb_mc_front_end;

    localparam int NCH = 4;
    localparam int SC  = 12;
    localparam int SB  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          start;
    logic [SC-1:0] size;
    logic [SB-1:0] sizeburst;
    logic [NCH-1:0] FSL_S_EXISTS;
    logic [NCH-1:0] rd_FSMctrl;
    logic [NCH-1:0] OUT_rdy;
    logic [NCH-1:0] FSL_S_READ;
    logic [NCH-1:0] IN_send;
    logic [SC:0]   IN_count;
    logic [1:0]    ch_sel;
    logic          busy;
    logic          done;

    mc_front_end #(.NCH(NCH), .SIZECOUNT(SC), .SIZEBURST(SB)) dut (
        .clk(clk), .rst(rst), .clear(clear), .start(start), .size(size),
        .sizeburst(sizeburst), .FSL_S_EXISTS(FSL_S_EXISTS),
        .rd_FSMctrl(rd_FSMctrl), .OUT_rdy(OUT_rdy), .FSL_S_READ(FSL_S_READ),
        .IN_send(IN_send), .IN_count(IN_count), .ch_sel(ch_sel),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int exp_q[$];
    int obs_q[$];
    int ch_tot[NCH];
    int done_cyc;
    int ndone;
    int bad;
    logic busy_after;
    logic [SC:0] obs_incount;

    // Queue the channel order expected for a run with equal per-channel sizes.
    task automatic build_exp(input int sz, input int sb);
        int rem[NCH];
        int blen;
        int n;
        bit any;
        blen = 1 << sb;
        exp_q.delete();
        for (int i = 0; i < NCH; i++) rem[i] = sz;
        do begin
            any = 1'b0;
            for (int ch = 0; ch < NCH; ch++) begin
                if (rem[ch] > 0) begin
                    n = (rem[ch] < blen) ? rem[ch] : blen;
                    repeat (n) exp_q.push_back(ch);
                    rem[ch] -= n;
                    any = 1'b1;
                end
            end
        end while (any);
    endtask

    // Launch a run and record what the DUT does until one cycle after done.
    task automatic do_run(input int sz, input int sb, input bit toggle, input bit noisy);
        int chn;
        obs_q.delete();
        for (int i = 0; i < NCH; i++) ch_tot[i] = 0;
        done_cyc    = -1;
        ndone       = 0;
        bad         = 0;
        busy_after  = 1'bx;
        obs_incount = '0;
        @(negedge clk);
        size      = SC'(sz);
        sizeburst = SB'(sb);
        start     = 1'b1;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            start = noisy && (done_cyc < 0);
            if (noisy) begin
                size      = SC'($urandom);
                sizeburst = SB'($urandom);
            end
            OUT_rdy      = toggle ? {3'b111, c[0]} : '1;
            FSL_S_EXISTS = toggle ? {1'b1, c[1], 2'b11} : '1;
            #1;
            if (c == 1) obs_incount = IN_count;
            else if (done_cyc < 0 && IN_count !== obs_incount) bad++;
            if (!$onehot0(IN_send)) bad++;
            if (FSL_S_READ !== (IN_send | rd_FSMctrl)) bad++;
            if (IN_send != '0) begin
                if ((IN_send & OUT_rdy & FSL_S_EXISTS) !== IN_send) bad++;
                if (IN_send !== (NCH'(1) << ch_sel)) bad++;
                chn = 0;
                for (int i = 0; i < NCH; i++) if (IN_send[i]) chn = i;
                obs_q.push_back(chn);
                ch_tot[chn]++;
            end
            if (done === 1'b1) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
                start = 1'b0;
            end
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                busy_after = busy;
                break;
            end
        end
        start        = 1'b0;
        OUT_rdy      = '1;
        FSL_S_EXISTS = '1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b, expected 0", done); else n_pass++;
        n_checks++; if (ch_sel !== 2'd0) $display("FAIL reset_ch_sel: got %0d, expected 0", ch_sel); else n_pass++;
        n_checks++; if (IN_send !== 4'b0) $display("FAIL reset_in_send: got %b, expected 0000", IN_send); else n_pass++;
        n_checks++; if (FSL_S_READ !== 4'b0) $display("FAIL reset_read: got %b, expected 0000", FSL_S_READ); else n_pass++;
        n_checks++; if (IN_count !== 13'd1) $display("FAIL reset_in_count: got %0d, expected 1", IN_count); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int e, o;
        build_exp(8, 2);
        do_run(8, 2, 1'b0, 1'b1);
        n_checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL rr_count: got %0d sends, expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL rr_order: got ch %0d, expected ch %0d", o, e); else n_pass++;
        end
        n_checks++; if (done_cyc !== 40) $display("FAIL rr_done_cycle: got %0d, expected 40", done_cyc); else n_pass++;
        n_checks++; if (ndone !== 1) $display("FAIL rr_done_pulses: got %0d, expected 1", ndone); else n_pass++;
        n_checks++; if (busy_after !== 1'b0) $display("FAIL rr_busy_after: got %b, expected 0", busy_after); else n_pass++;
        n_checks++; if (obs_incount !== 13'd4) $display("FAIL rr_in_count: got %0d, expected 4", obs_incount); else n_pass++;
        n_checks++; if (bad !== 0) $display("FAIL rr_strobes: got %0d bad cycles, expected 0", bad); else n_pass++;
    endtask

    task automatic test_backpressure();
        int e, o;
        build_exp(4, 1);
        do_run(4, 1, 1'b1, 1'b0);
        n_checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL bp_count: got %0d sends, expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL bp_order: got ch %0d, expected ch %0d", o, e); else n_pass++;
        end
        for (int i = 0; i < NCH; i++) begin
            n_checks++; if (ch_tot[i] !== 4) $display("FAIL bp_total_ch%0d: got %0d, expected 4", i, ch_tot[i]); else n_pass++;
        end
        n_checks++; if (bad !== 0) $display("FAIL bp_gating: got %0d bad cycles, expected 0", bad); else n_pass++;
        n_checks++; if (ndone !== 1) $display("FAIL bp_done_pulses: got %0d, expected 1", ndone); else n_pass++;
    endtask

    task automatic test_partial_skip();
        int e, o;
        build_exp(5, 2);
        do_run(5, 2, 1'b0, 1'b0);
        n_checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL part_count: got %0d sends, expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL part_order: got ch %0d, expected ch %0d", o, e); else n_pass++;
        end
        // 20 words plus 8 bursts (one ARB gap each, the last replaced by DONE).
        n_checks++; if (done_cyc !== 28) $display("FAIL part_done_cycle: got %0d, expected 28", done_cyc); else n_pass++;
        n_checks++; if (bad !== 0) $display("FAIL part_strobes: got %0d bad cycles, expected 0", bad); else n_pass++;
    endtask

    task automatic test_edge_sizes();
        int e, o;
        do_run(0, 2, 1'b0, 1'b0);
        n_checks++; if (obs_q.size() !== 0) $display("FAIL size0_sends: got %0d, expected 0", obs_q.size()); else n_pass++;
        n_checks++; if (done_cyc !== 1) $display("FAIL size0_done_cycle: got %0d, expected 1", done_cyc); else n_pass++;
        n_checks++; if (ndone !== 1) $display("FAIL size0_done_pulses: got %0d, expected 1", ndone); else n_pass++;
        build_exp(2, 0);
        do_run(2, 0, 1'b0, 1'b0);
        n_checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL sb0_count: got %0d sends, expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL sb0_order: got ch %0d, expected ch %0d", o, e); else n_pass++;
        end
        n_checks++; if (done_cyc !== 16) $display("FAIL sb0_done_cycle: got %0d, expected 16", done_cyc); else n_pass++;
        n_checks++; if (obs_incount !== 13'd1) $display("FAIL sb0_in_count: got %0d, expected 1", obs_incount); else n_pass++;
    endtask

    task automatic test_clear();
        int sends;
        int e, o;
        bit saw_done;
        sends = 0;
        @(negedge clk);
        size = 12'd8; sizeburst = 4'd2; start = 1'b1;
        for (int c = 0; c < 20 && sends < 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (IN_send != '0) sends++;
        end
        @(negedge clk);
        clear = 1'b1;
        #1;
        n_checks++; if (IN_send !== 4'b0) $display("FAIL clear_strobe: got %b, expected 0000", IN_send); else n_pass++;
        n_checks++; if (FSL_S_READ !== 4'b0) $display("FAIL clear_read: got %b, expected 0000", FSL_S_READ); else n_pass++;
        @(negedge clk);
        clear = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL clear_busy: got %b, expected 0", busy); else n_pass++;
        n_checks++; if (ch_sel !== 2'd0) $display("FAIL clear_ch_sel: got %0d, expected 0", ch_sel); else n_pass++;
        saw_done = (done === 1'b1);
        repeat (3) begin
            @(negedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        n_checks++; if (saw_done !== 1'b0) $display("FAIL clear_no_done: got %b, expected 0", saw_done); else n_pass++;
        build_exp(2, 2);
        do_run(2, 2, 1'b0, 1'b0);
        n_checks++; if (obs_q.size() !== 8) $display("FAIL restart_count: got %0d sends, expected 8", obs_q.size()); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL restart_order: got ch %0d, expected ch %0d", o, e); else n_pass++;
        end
        n_checks++; if (done_cyc !== 12) $display("FAIL restart_done_cycle: got %0d, expected 12", done_cyc); else n_pass++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        size = 12'd8; sizeburst = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (IN_send !== 4'b0) $display("FAIL rstmid_strobe: got %b, expected 0000", IN_send); else n_pass++;
        n_checks++; if (FSL_S_READ !== 4'b0) $display("FAIL rstmid_read: got %b, expected 0000", FSL_S_READ); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b, expected 0", busy); else n_pass++;
        n_checks++; if (ch_sel !== 2'd0) $display("FAIL rstmid_ch_sel: got %0d, expected 0", ch_sel); else n_pass++;
        n_checks++; if (IN_count !== 13'd1) $display("FAIL rstmid_in_count: got %0d, expected 1", IN_count); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rstmid_done: got %b, expected 0", done); else n_pass++;
    endtask

    task automatic test_ctrl_read();
        int e, o;
        @(negedge clk);
        rd_FSMctrl = 4'b0010;
        #1;
        n_checks++; if (FSL_S_READ !== 4'b0010) $display("FAIL ctrl_read: got %b, expected 0010", FSL_S_READ); else n_pass++;
        n_checks++; if (IN_send !== 4'b0) $display("FAIL ctrl_in_send: got %b, expected 0000", IN_send); else n_pass++;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL ctrl_busy: got %b, expected 0", busy); else n_pass++;
        rd_FSMctrl = 4'b0000;
        build_exp(1, 0);
        do_run(1, 0, 1'b0, 1'b0);
        n_checks++; if (obs_q.size() !== 4) $display("FAIL ctrl_run_count: got %0d sends, expected 4", obs_q.size()); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL ctrl_run_order: got ch %0d, expected ch %0d", o, e); else n_pass++;
        end
        n_checks++; if (done_cyc !== 8) $display("FAIL ctrl_run_done_cycle: got %0d, expected 8", done_cyc); else n_pass++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b0;
        clear        = 1'b0;
        start        = 1'b0;
        size         = '0;
        sizeburst    = '0;
        FSL_S_EXISTS = '1;
        OUT_rdy      = '1;
        rd_FSMctrl   = '0;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_partial_skip();
        test_edge_sizes();
        test_clear();
        test_reset_mid();
        test_ctrl_read();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
